// File: rtl/pbchk_rx.sv
// Serial frame receiver: start, 4 data bits (MSB first), parity, stop.
// Reports data, parity/framing errors and a saturating error-frame count.
module pbchk_rx #(
   parameter bit ODD_PAR = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_en,
   input  logic       inp,
   output logic [3:0] out_data,
   output logic       out_valid,
   output logic       out_perr,
   output logic       out_ferr,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2,
      STOP = 2'd3
   } state_t;

   state_t     state;
   logic [1:0] bit_cnt;
   logic [3:0] shift;
   logic       par_bit;

   // Frame fails when the XOR of data and parity differs from the selected sense.
   function automatic logic parity_err(input logic [3:0] d, input logic p);
      return ((^d) ^ p) != ODD_PAR;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   logic perr_now;
   logic ferr_now;

   always_comb begin
      perr_now = parity_err(shift, par_bit);
      ferr_now = ~inp;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= 2'd0;
         shift     <= 4'h0;
         par_bit   <= 1'b0;
         out_data  <= 4'h0;
         out_valid <= 1'b0;
         out_perr  <= 1'b0;
         out_ferr  <= 1'b0;
         err_cnt   <= 8'h00;
      end else begin
         out_valid <= 1'b0;
         if (bit_en) begin
            case (state)
               IDLE: begin
                  bit_cnt <= 2'd0;
                  if (!inp) state <= DATA;
               end
               DATA: begin
                  // First data bit ends up in the MSB after four shifts.
                  shift   <= {shift[2:0], inp};
                  bit_cnt <= bit_cnt + 2'd1;
                  if (bit_cnt == 2'd3) state <= PAR;
               end
               PAR: begin
                  par_bit <= inp;
                  state   <= STOP;
               end
               STOP: begin
                  out_data  <= shift;
                  out_perr  <= perr_now;
                  out_ferr  <= ferr_now;
                  out_valid <= 1'b1;
                  if (perr_now || ferr_now) err_cnt <= sat_inc(err_cnt);
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pbchk_rx.sv
// Bench for pbchk_rx: even and odd parity instances share one stimulus stream
// and are compared every cycle against a frame-level model.
module tb_pbchk_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bit_en = 1'b0;
   logic       inp = 1'b1;
   logic [3:0] data0, data1;
   logic       v0, v1, pe0, pe1, fe0, fe1;
   logic [7:0] cnt0, cnt1;

   always #5 clk = ~clk;

   pbchk_rx #(.ODD_PAR(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .inp(inp),
      .out_data(data0), .out_valid(v0), .out_perr(pe0), .out_ferr(fe0), .err_cnt(cnt0)
   );

   pbchk_rx #(.ODD_PAR(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .inp(inp),
      .out_data(data1), .out_valid(v1), .out_perr(pe1), .out_ferr(fe1), .err_cnt(cnt1)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: collect samples from a start bit, decode once seven are in hand.
   bit         samp[$];
   logic [3:0] m_data;
   logic       m_valid;
   logic       m_ferr;
   logic       m_perr[2];
   int         m_cnt[2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp.delete();
         m_data = 4'h0; m_valid = 1'b0; m_ferr = 1'b0;
         m_perr[0] = 1'b0; m_perr[1] = 1'b0;
         m_cnt[0] = 0; m_cnt[1] = 0;
      end else begin
         m_valid = 1'b0;
         if (bit_en) begin
            if (samp.size() > 0 || inp == 1'b0) samp.push_back(inp);
            if (samp.size() == 7) begin
               m_data  = {samp[1], samp[2], samp[3], samp[4]};
               m_ferr  = (samp[6] == 1'b0);
               m_valid = 1'b1;
               for (int k = 0; k < 2; k++) begin
                  m_perr[k] = ((samp[1] ^ samp[2] ^ samp[3] ^ samp[4] ^ samp[5]) != k[0]);
                  if ((m_perr[k] || m_ferr) && m_cnt[k] < 255) m_cnt[k]++;
               end
               samp.delete();
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         check("even_valid", v0, m_valid);
         check("even_data", data0, m_data);
         check("even_perr", pe0, m_perr[0]);
         check("even_ferr", fe0, m_ferr);
         check("even_cnt", cnt0, m_cnt[0]);
         check("odd_valid", v1, m_valid);
         check("odd_data", data1, m_data);
         check("odd_perr", pe1, m_perr[1]);
         check("odd_ferr", fe1, m_ferr);
         check("odd_cnt", cnt1, m_cnt[1]);
      end
   end

   // Record delivered nibbles of the even instance for literal checks.
   int         vcount = 0;
   logic [3:0] cap[$];

   always @(posedge clk) begin
      #1;
      if (rst_n && v0) begin
         vcount++;
         cap.push_back(data0);
      end
   end

   // f[6] is the start bit, sent first; n bits are sent from the top.
   task automatic send_bits(input logic [6:0] f, input int n, input int gap);
      for (int i = 6; i > 6 - n; i--) begin
         @(negedge clk);
         inp = f[i];
         bit_en = 1'b1;
         for (int g = 1; g < gap; g++) begin
            @(negedge clk);
            bit_en = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n, input logic en);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         inp = 1'b1;
         bit_en = en;
      end
   endtask

   int vbase;

   initial begin
      idle(3, 1'b0);
      check("rst_data", data0, 0);
      check("rst_valid", v0, 0);
      check("rst_perr", pe0, 0);
      check("rst_ferr", fe0, 0);
      check("rst_cnt", cnt0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Good even frame, data B
      send_bits(7'b0101111, 7, 1);
      idle(3, 1'b1);
      check("r28_data", data0, 4'hB);
      check("r28_perr", pe0, 0);
      check("r28_ferr", fe0, 0);
      check("r28_cnt", cnt0, 0);
      check("r28_pulses", vcount, 1);
      check("r28_odd_perr", pe1, 1);

      // Parity error
      send_bits(7'b0101101, 7, 1);
      idle(3, 1'b1);
      check("r29_data", data0, 4'hB);
      check("r29_perr", pe0, 1);
      check("r29_cnt", cnt0, 1);

      // All-zero frame: framing error
      send_bits(7'b0000000, 7, 1);
      idle(3, 1'b1);
      check("r30_data", data0, 4'h0);
      check("r30_perr", pe0, 0);
      check("r30_ferr", fe0, 1);
      check("r30_cnt", cnt0, 2);
      check("r30_pulses", vcount, 3);

      // Sparse strobes, back-to-back frames 3 then C, then idle-high samples
      vbase = vcount;
      send_bits(7'b0001101, 7, 4);
      send_bits(7'b0110001, 7, 4);
      idle(20, 1'b1);
      check("r31_pulses", vcount - vbase, 2);
      check("r31_first", cap[cap.size() - 2], 4'h3);
      check("r31_second", cap[cap.size() - 1], 4'hC);

      // Reset after three data bits of a frame
      send_bits(7'b0101111, 4, 1);
      @(negedge clk);
      bit_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("r32_rst_data", data0, 0);
      check("r32_rst_cnt", cnt0, 0);
      check("r32_rst_valid", v0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send_bits(7'b0010101, 7, 1);
      idle(3, 1'b0);
      check("r32_data", data0, 4'h5);
      check("r32_perr", pe0, 0);
      check("r32_cnt", cnt0, 0);

      // 300 frames failing odd parity, back to back
      for (int i = 0; i < 300; i++) send_bits(7'b0000001, 7, 1);
      idle(3, 1'b1);
      check("r33_odd_cnt", cnt1, 255);
      check("r33_even_cnt", cnt0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
